dm_cache_ctrl: RTL and testbench

//   Direct-mapped, write-through, no-write-allocate cache between the CPU load/store port and the byte-addressed

---
 rtl/dm_cache_ctrl.sv | 156 +++++++++++++++
 tb/tb_dm_cache_ctrl.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dm_cache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate cache between a CPU load/store port and a byte-addressed SRAM.
// Lines are 16 bytes (four 32-bit words); read misses refill one word per cycle, writes always go through to SRAM.
module dm_cache_ctrl #(
    parameter int ADDR_W     = 16,
    parameter int INDEX_BITS = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic [3:0]        cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [31:0]       cpu_wdata,
    output logic [31:0]       cpu_rdata,
    output logic              cpu_stall,
    output logic [3:0]        mem_w_en,
    output logic [ADDR_W-1:0] mem_address,
    output logic [31:0]       mem_write_data,
    input  logic [31:0]       mem_read_data,
    output logic [15:0]       hit_cnt,
    output logic [15:0]       miss_cnt
);
    localparam int TAG_W = ADDR_W - INDEX_BITS - 4;
    localparam int LINES = 1 << INDEX_BITS;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REFILL,
        ST_WRITE
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic [1:0]       r_cnt;
    logic             r_after_refill;
    logic [LINES-1:0] r_valid;
    logic [TAG_W-1:0] r_tag  [LINES];
    logic [31:0]      r_data [LINES][4];
    logic [15:0]      r_hit_cnt;
    logic [15:0]      r_miss_cnt;

    logic [TAG_W-1:0]      w_tag;
    logic [INDEX_BITS-1:0] w_index;
    logic [1:0]            w_word;
    logic [1:0]            w_off;
    logic                  w_is_write;
    logic                  w_hit;
    logic [31:0]           w_line_word;
    logic [3:0]            w_be;
    logic [31:0]           w_wdata_sh;
    logic                  w_count_hit;
    logic                  w_count_miss;

    assign w_tag   = cpu_addr[ADDR_W-1 -: TAG_W];
    assign w_index = cpu_addr[INDEX_BITS+3:4];
    assign w_word  = cpu_addr[3:2];
    assign w_off   = cpu_addr[1:0];

    // Only the three legal write encodings count as writes; anything else is a read.
    assign w_is_write = (cpu_we == 4'b0001) || (cpu_we == 4'b0011) || (cpu_we == 4'b1111);

    assign w_hit       = r_valid[w_index] && (r_tag[w_index] == w_tag);
    assign w_line_word = r_data[w_index][w_word];
    assign cpu_rdata   = w_hit ? (w_line_word >> {w_off, 3'b000}) : 32'h0;

    assign w_be       = cpu_we << w_off;
    assign w_wdata_sh = cpu_wdata << {w_off, 3'b000};

    assign hit_cnt  = r_hit_cnt;
    assign miss_cnt = r_miss_cnt;

    // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
    always_comb begin
        w_next_state   = r_state;
        cpu_stall      = 1'b0;
        mem_w_en       = 4'b0000;
        mem_address    = '0;
        mem_write_data = 32'h0;
        w_count_hit    = 1'b0;
        w_count_miss   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (cpu_req) begin
                    if (w_is_write) begin
                        cpu_stall    = 1'b1;
                        w_next_state = ST_WRITE;
                    end else if (w_hit) begin
                        w_count_hit = !r_after_refill;
                    end else begin
                        cpu_stall    = 1'b1;
                        w_count_miss = 1'b1;
                        w_next_state = ST_REFILL;
                    end
                end
            end
            ST_REFILL: begin
                cpu_stall   = 1'b1;
                mem_address = {w_tag, w_index, r_cnt, 2'b00};
                if (r_cnt == 2'd3) begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_WRITE: begin
                mem_w_en       = w_is_write ? cpu_we : 4'b0000;
                mem_address    = cpu_addr;
                mem_write_data = cpu_wdata;
                w_next_state   = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= ST_IDLE;
            r_cnt          <= 2'd0;
            r_after_refill <= 1'b0;
            r_valid        <= '0;
            r_hit_cnt      <= 16'h0;
            r_miss_cnt     <= 16'h0;
        end else begin
            r_state        <= w_next_state;
            r_after_refill <= (r_state == ST_REFILL);
            r_cnt          <= (r_state == ST_REFILL) ? r_cnt + 2'd1 : 2'd0;
            // Valid is raised only on the final beat so an interrupted refill leaves the line invalid.
            if (r_state == ST_REFILL && r_cnt == 2'd3) begin
                r_valid[w_index] <= 1'b1;
            end
            if (w_count_hit && r_hit_cnt != 16'hFFFF) begin
                r_hit_cnt <= r_hit_cnt + 16'd1;
            end
            if (w_count_miss && r_miss_cnt != 16'hFFFF) begin
                r_miss_cnt <= r_miss_cnt + 16'd1;
            end
        end
    end

    // NOTE: tag and data arrays carry no reset; the valid bits alone decide whether their contents are used.
    always_ff @(posedge clk) begin
        if (r_state == ST_REFILL) begin
            r_data[w_index][r_cnt] <= mem_read_data;
            if (r_cnt == 2'd3) begin
                r_tag[w_index] <= w_tag;
            end
        end
        if (r_state == ST_WRITE && w_is_write && w_hit) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b]) begin
                    r_data[w_index][w_word][8*b +: 8] <= w_wdata_sh[8*b +: 8];
                end
            end
        end
    end
endmodule

// File: tb/tb_dm_cache_ctrl.sv
// Self-checking bench for dm_cache_ctrl: directed scenarios plus randomized traffic checked against
// a flat byte-memory model and a per-line valid/tag table.
module tb_dm_cache_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req;
    logic [3:0]  cpu_we;
    logic [15:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        cpu_stall;
    logic [3:0]  mem_w_en;
    logic [15:0] mem_address;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;
    logic [15:0] hit_cnt;
    logic [15:0] miss_cnt;

    int checks;
    int errors;

    logic [7:0] sram    [65536];
    logic [7:0] ref_mem [65536];
    logic       tb_load;

    bit [15:0]  m_valid;
    logic [7:0] m_tag [16];
    int         m_hits;
    int         m_misses;

    always #5 clk = ~clk;

    dm_cache_ctrl #(.ADDR_W(16), .INDEX_BITS(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .cpu_req        (cpu_req),
        .cpu_we         (cpu_we),
        .cpu_addr       (cpu_addr),
        .cpu_wdata      (cpu_wdata),
        .cpu_rdata      (cpu_rdata),
        .cpu_stall      (cpu_stall),
        .mem_w_en       (mem_w_en),
        .mem_address    (mem_address),
        .mem_write_data (mem_write_data),
        .mem_read_data  (mem_read_data),
        .hit_cnt        (hit_cnt),
        .miss_cnt       (miss_cnt)
    );

    // SRAM: byte lane i of write_data lands at address+i; reads are combinational.
    always @(posedge clk) begin
        if (tb_load) begin
            for (int i = 0; i < 65536; i++) sram[i] <= ref_mem[i];
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (mem_w_en[i]) sram[16'(mem_address + 16'(i))] <= mem_write_data[8*i +: 8];
            end
        end
    end

    assign mem_read_data = {sram[16'(mem_address + 16'd3)], sram[16'(mem_address + 16'd2)],
                            sram[16'(mem_address + 16'd1)], sram[mem_address]};

    function automatic logic [31:0] ref_read(input logic [15:0] a);
        logic [15:0] al;
        logic [31:0] w;
        al = {a[15:2], 2'b00};
        w  = {ref_mem[16'(al + 16'd3)], ref_mem[16'(al + 16'd2)], ref_mem[16'(al + 16'd1)], ref_mem[al]};
        return w >> (8 * a[1:0]);
    endfunction

    task automatic model_reset();
        m_valid  = '0;
        m_hits   = 0;
        m_misses = 0;
    endtask

    task automatic do_read(input logic [15:0] a, input logic [3:0] we, input string name,
                           output logic [31:0] got);
        int          stalls;
        int          exp_stalls;
        bit          exp_hit;
        logic [31:0] exp_data;
        logic [15:0] exp_addr;
        exp_hit    = m_valid[a[7:4]] && (m_tag[a[7:4]] == a[15:8]);
        exp_stalls = exp_hit ? 0 : 5;
        exp_data   = ref_read(a);
        @(negedge clk);
        cpu_req   = 1'b1;
        cpu_we    = we;
        cpu_addr  = a;
        cpu_wdata = $urandom;
        #1;
        stalls = 0;
        while (cpu_stall === 1'b1 && stalls < 20) begin
            if (stalls >= 1 && stalls <= 4) begin
                exp_addr = {a[15:4], 2'(stalls - 1), 2'b00};
                checks++;
                if (mem_address !== exp_addr || mem_w_en !== 4'b0000) begin
                    errors++;
                    $display("FAIL %s refill beat %0d: addr=%h w_en=%b, expected addr=%h w_en=0000",
                             name, stalls - 1, mem_address, mem_w_en, exp_addr);
                end
            end
            @(posedge clk);
            #1;
            stalls++;
        end
        checks++;
        if (stalls != exp_stalls) begin
            errors++;
            $display("FAIL %s stall cycles: got %0d, expected %0d", name, stalls, exp_stalls);
        end
        checks++;
        if (cpu_rdata !== exp_data) begin
            errors++;
            $display("FAIL %s rdata addr=%h: got %h, expected %h", name, a, cpu_rdata, exp_data);
        end
        checks++;
        if (mem_w_en !== 4'b0000 || mem_address !== 16'h0) begin
            errors++;
            $display("FAIL %s idle SRAM traffic: w_en=%b addr=%h, expected 0000/0000", name, mem_w_en, mem_address);
        end
        got = cpu_rdata;
        if (exp_hit) begin
            if (m_hits < 65535) m_hits++;
        end else begin
            m_valid[a[7:4]] = 1'b1;
            m_tag[a[7:4]]   = a[15:8];
            if (m_misses < 65535) m_misses++;
        end
        @(posedge clk);
        #1;
        checks++;
        if (hit_cnt !== 16'(m_hits) || miss_cnt !== 16'(m_misses)) begin
            errors++;
            $display("FAIL %s counters: hit=%0d miss=%0d, expected hit=%0d miss=%0d",
                     name, hit_cnt, miss_cnt, m_hits, m_misses);
        end
    endtask

    task automatic do_write(input logic [15:0] a, input logic [3:0] we, input logic [31:0] d, input string name);
        @(negedge clk);
        cpu_req   = 1'b1;
        cpu_we    = we;
        cpu_addr  = a;
        cpu_wdata = d;
        #1;
        checks++;
        if (cpu_stall !== 1'b1) begin
            errors++;
            $display("FAIL %s request cycle stall: got %b, expected 1", name, cpu_stall);
        end
        @(posedge clk);
        #1;
        checks++;
        if (cpu_stall !== 1'b0 || mem_w_en !== we || mem_address !== a || mem_write_data !== d) begin
            errors++;
            $display("FAIL %s write cycle: stall=%b w_en=%b addr=%h data=%h, expected 0/%b/%h/%h",
                     name, cpu_stall, mem_w_en, mem_address, mem_write_data, we, a, d);
        end
        for (int i = 0; i < 4; i++) begin
            if (we[i]) ref_mem[16'(a + 16'(i))] = d[8*i +: 8];
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        @(posedge clk);
        #1;
        checks++;
        if (cpu_stall !== 1'b0 || mem_w_en !== 4'b0000 || mem_address !== 16'h0 || mem_write_data !== 32'h0) begin
            errors++;
            $display("FAIL reset outputs: stall=%b w_en=%b addr=%h wdata=%h, expected all zero",
                     cpu_stall, mem_w_en, mem_address, mem_write_data);
        end
        checks++;
        if (hit_cnt !== 16'h0 || miss_cnt !== 16'h0 || cpu_rdata !== 32'h0) begin
            errors++;
            $display("FAIL reset counters: hit=%h miss=%h rdata=%h, expected 0/0/0", hit_cnt, miss_cnt, cpu_rdata);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_read_miss();
        logic [31:0] got;
        do_read(16'h0040, 4'b0000, "miss_0040", got);
        checks++;
        if (got !== 32'hDEADBEEF || hit_cnt !== 16'd0 || miss_cnt !== 16'd1) begin
            errors++;
            $display("FAIL first miss: rdata=%h hit=%0d miss=%0d, expected deadbeef/0/1", got, hit_cnt, miss_cnt);
        end
    endtask

    task automatic test_read_hit();
        logic [31:0] got;
        do_read(16'h0044, 4'b0000, "hit_0044", got);
        checks++;
        if (hit_cnt !== 16'd1) begin
            errors++;
            $display("FAIL first hit count: got %0d, expected 1", hit_cnt);
        end
    endtask

    task automatic test_write_hit();
        logic [31:0] got;
        do_write(16'h0041, 4'b0001, 32'h000000AA, "byte_write_0041");
        do_read(16'h0040, 4'b0000, "read_after_byte_write", got);
        checks++;
        if (got !== 32'hDEADAAEF) begin
            errors++;
            $display("FAIL merged word: got %h, expected deadaaef", got);
        end
    endtask

    task automatic test_write_miss();
        logic [31:0] got;
        do_read(16'h0000, 4'b0000, "fill_0000", got);
        do_write(16'h0400, 4'b1111, 32'h12345678, "word_write_0400");
        do_read(16'h0000, 4'b0000, "still_hit_0000", got);
        do_read(16'h0400, 4'b0000, "miss_0400", got);
        checks++;
        if (got !== 32'h12345678) begin
            errors++;
            $display("FAIL no-allocate read-back: got %h, expected 12345678", got);
        end
    endtask

    task automatic test_reset_mid_refill();
        logic [31:0] got;
        @(negedge clk);
        cpu_req  = 1'b1;
        cpu_we   = 4'b0000;
        cpu_addr = 16'h0080;
        @(posedge clk);
        @(posedge clk);
        #1;
        checks++;
        if (cpu_stall !== 1'b1 || mem_address !== 16'h0084) begin
            errors++;
            $display("FAIL refill beat 1 before reset: stall=%b addr=%h, expected 1/0084", cpu_stall, mem_address);
        end
        @(negedge clk);
        rst     = 1'b1;
        cpu_req = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (cpu_stall !== 1'b0 || mem_w_en !== 4'b0000 || mem_address !== 16'h0 || mem_write_data !== 32'h0 ||
            hit_cnt !== 16'h0 || miss_cnt !== 16'h0 || cpu_rdata !== 32'h0) begin
            errors++;
            $display("FAIL mid-refill reset: stall=%b w_en=%b addr=%h wdata=%h hit=%h miss=%h rdata=%h, expected all zero",
                     cpu_stall, mem_w_en, mem_address, mem_write_data, hit_cnt, miss_cnt, cpu_rdata);
        end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        do_read(16'h0080, 4'b0000, "reread_0080", got);
    endtask

    task automatic test_evict();
        logic [31:0] got;
        @(negedge clk);
        rst     = 1'b1;
        cpu_req = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        do_read(16'h0010, 4'b0000, "evict_a", got);
        do_read(16'h0110, 4'b0000, "evict_b", got);
        do_read(16'h0010, 4'b0000, "evict_a_again", got);
        checks++;
        if (miss_cnt !== 16'd3) begin
            errors++;
            $display("FAIL eviction miss count: got %0d, expected 3", miss_cnt);
        end
    endtask

    task automatic test_invalid_we();
        logic [31:0] got;
        do_read(16'h0014, 4'b0101, "we_0101_as_read", got);
        do_read(16'h0012, 4'b1000, "we_1000_as_read", got);
        do_read(16'h0010, 4'b0111, "we_0111_as_read", got);
    endtask

    task automatic test_random();
        logic [31:0] got;
        logic [15:0] a;
        logic [3:0]  we;
        int          kind;
        for (int n = 0; n < 200; n++) begin
            kind = $urandom_range(0, 9);
            a    = {6'd0, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15))};
            if (kind < 6) begin
                do_read(a, 4'b0000, "rand_read", got);
            end else if (kind < 9) begin
                case ($urandom_range(0, 2))
                    0:       do_write(a, 4'b0001, $urandom, "rand_byte");
                    1:       do_write({a[15:1], 1'b0}, 4'b0011, $urandom, "rand_half");
                    default: do_write({a[15:2], 2'b00}, 4'b1111, $urandom, "rand_word");
                endcase
            end else begin
                we = 4'($urandom_range(1, 15));
                if (we == 4'b0001 || we == 4'b0011 || we == 4'b1111) we = 4'b0010;
                do_read(a, we, "rand_bad_we", got);
            end
        end
    endtask

    task automatic test_hit_saturation();
        logic [31:0] got;
        do_read(16'h0040, 4'b0000, "sat_prime", got);
        @(negedge clk);
        cpu_req  = 1'b1;
        cpu_we   = 4'b0000;
        cpu_addr = 16'h0040;
        repeat (65540) @(posedge clk);
        #1;
        checks++;
        if (hit_cnt !== 16'hFFFF || cpu_stall !== 1'b0) begin
            errors++;
            $display("FAIL hit counter saturation: hit=%h stall=%b, expected ffff/0", hit_cnt, cpu_stall);
        end
        @(negedge clk);
        cpu_req = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        cpu_req   = 1'b0;
        cpu_we    = 4'b0000;
        cpu_addr  = 16'h0;
        cpu_wdata = 32'h0;
        tb_load   = 1'b1;
        for (int i = 0; i < 65536; i++) ref_mem[i] = 8'($urandom);
        ref_mem[16'h0040] = 8'hEF;
        ref_mem[16'h0041] = 8'hBE;
        ref_mem[16'h0042] = 8'hAD;
        ref_mem[16'h0043] = 8'hDE;
        model_reset();
        @(posedge clk);
        #1;
        tb_load = 1'b0;

        test_reset();
        test_read_miss();
        test_read_hit();
        test_write_hit();
        test_write_miss();
        test_reset_mid_refill();
        test_evict();
        test_invalid_we();
        test_random();
        test_hit_saturation();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
